m10_spi_slave_responder: RTL and testbench
==========================================

# m10_spi_slave_responder

Synthesizable SPI slave that models the MAX10 BMC end of the PMCI ingress/egress SPI links. The FPGA-side PMCI acts as SPI master. This block oversamples the master's SCLK, CSn and MOSI on the local system clock, deserialises MOSI into bytes for the BMC-side consumer, and serialises bytes from a BMC-side source onto MISO. One instance serves one link, ingress or egress. Used in emulation and as the reference responder in the PMCI MCTP bench.

## Interface
Parameters:
- IDLE_BYTE, 8'h00: byte shifted out on MISO when no tx byte is available (underrun fill).
- CNT_W, 16: width of the status counters (only used with M10_SPI_STATS_EN).

Ports:
- clk  in  1  system clock; must run at ≥8× the SPI clock rate.
- reset  in  1  synchronous, active-high reset.
- spi_clk  in  1  SPI clock from the master, asynchronous to clk; SPI mode 0.
- spi_csn  in  1  chip select, active low, asynchronous.
- spi_mosi  in  1  master-out data, asynchronous.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO output enable; high only while the synchronised csn is low.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- rx_overflow  out  1  sticky; set when a byte completes while rx_valid is high and rx_ready is low.
- tx_data  in  8  next byte to transmit.
- tx_valid  in  1  tx_data is available.
- tx_ready  out  1  single-cycle pop strobe; tx_data is consumed in that cycle.
- tx_underrun  out  1  sticky; set when a load occurs with tx_valid low.
- err_clr  in  1  clears rx_overflow and tx_underrun.
- frame_cnt, byte_cnt  out  CNT_W  completed frames and bytes (only with M10_SPI_STATS_EN).

## Operation
- Inputs spi_clk, spi_csn and spi_mosi each pass a 2-FF synchroniser, then a previous-value register. This yields the events sclk_rise, sclk_fall, csn_fall and csn_rise.
- States: IDLE, then ACTIVE.
  - IDLE to ACTIVE on csn_fall.
  - ACTIVE to IDLE on csn_rise.
- On csn_fall:
  - bit_cnt clears to 0.
  - The tx shifter loads tx_data and pulses tx_ready, or loads IDLE_BYTE and sets tx_underrun if tx_valid is low.
- In ACTIVE on sclk_rise:
  - The synchronised MOSI shifts into rx_shift, MSB first.
  - bit_cnt increments.
  - When bit_cnt wraps 7 to 0, the completed byte is written to rx_data and rx_valid is set.
  - If rx_valid was already set and was not consumed in the same cycle, the new byte is dropped, rx_data is kept and rx_overflow is set.
- In ACTIVE on sclk_fall:
  - If bit_cnt == 0 and at least one byte has completed in this frame, the tx shifter loads the next byte (same pop and underrun rules as above).
  - Otherwise the tx shifter shifts left by one.
- spi_miso always equals tx_shift[7].
- csn_rise with a partial byte (bit_cnt ≠ 0): the partial rx byte is discarded, no rx_valid is raised, and the tx shifter is not popped again.
- Events during IDLE: sclk edges are ignored.
- rx_valid clears on a handshake. If a handshake and a byte completion happen in the same cycle, rx_valid stays 1 with the new data and no overflow is flagged.
- err_clr has priority over a same-cycle set.

## Timing
- Reset values:
  - Outputs: spi_miso=0, spi_miso_oe=0, rx_data=0, rx_valid=0, tx_ready=0, rx_overflow=0, tx_underrun=0, counters=0.
  - Internal: state=IDLE, bit_cnt=0.
- Reset mid-frame: all state returns to reset values. The next byte is only accepted after a fresh csn_fall.
- Pin to event latency is 3 clk: two synchroniser stages plus the edge compare.
- rx_valid rises 4 clk after the 8th SCLK rising edge at the pin.
- MISO updates 4 clk after an SCLK falling edge at the pin. This is why SCLK high and low times must each be ≥4 clk; the ≥8× clock ratio guarantees it.
- tx_ready is a one-cycle pulse coincident with the load. tx_data must be stable while tx_valid is high.

## Configuration
- M10_SPI_STATS_EN:
  - Defined: frame_cnt increments on every csn_rise that follows at least one completed byte. byte_cnt increments on every completed rx byte. Both counters wrap at 2^CNT_W.
  - Not defined: the frame_cnt and byte_cnt ports are absent and no counter logic is built.

## Structure
- Package m10_spi_pkg holds:
  - the state enum (IDLE, ACTIVE);
  - localparams BYTE_W=8 and SYNC_STAGES=2;
  - the default IDLE_BYTE.
- Sub-module m10_spi_sync contains one 2-FF synchroniser plus an edge detector, with outputs level, rise and fall. The responder instantiates it three times.

## Test plan
- Single frame: master sends 8'hA5 with tx_data=8'h3C queued → rx_data=8'hA5 with one rx_valid; master samples MISO as 8'h3C; exactly one tx_ready pulse.
- Back-to-back frame: 4 bytes 01,02,03,04 with rx_ready held high and tx source 10..13 → four rx_valid pulses in order; MISO carries 10,11,12,13; byte_cnt=4 and frame_cnt=1 with STATS_EN.
- Rx overflow: rx_ready held low, 2 bytes AA,BB → rx_data=AA, rx_overflow=1; err_clr → rx_overflow=0.
- Tx underrun: tx_valid low, 1 byte → MISO returns IDLE_BYTE (00); tx_underrun=1.
- Partial byte: CSn rises after 5 bits → no rx_valid; the next frame's byte 0x5A is received correctly.
- Reset mid-byte: reset asserted after 3 bits, then a new frame with 0xC3 → outputs at reset values during reset; 0xC3 is received intact.

Source files
------------

// File: rtl/m10_spi_pkg.sv
// Shared types and constants for the MAX10 BMC-side SPI responder.
package m10_spi_pkg;

    localparam int BYTE_W      = 8;
    localparam int SYNC_STAGES = 2;

    localparam logic [BYTE_W-1:0] DEFAULT_IDLE_BYTE = 8'h00;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/m10_spi_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, followed by a registered edge detector.
module m10_spi_sync
    import m10_spi_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // level, rise and fall are registered together so they stay aligned with each other.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
            level  <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

endmodule

// File: rtl/m10_spi_slave_responder.sv
// Oversampled SPI mode-0 slave for one PMCI link: MOSI bytes out to rx_*, tx_* bytes onto MISO.
// Optional status counters frame_cnt/byte_cnt are built when M10_SPI_STATS_EN is defined.
module m10_spi_slave_responder
    import m10_spi_pkg::*;
#(
    parameter logic [BYTE_W-1:0] IDLE_BYTE = DEFAULT_IDLE_BYTE,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_csn,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overflow,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    input  logic              err_clr
`ifdef M10_SPI_STATS_EN
    ,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  byte_cnt
`endif
);

    logic unused_sclk_lvl;
    logic sclk_rise, sclk_fall;
    logic csn_lvl, csn_rise, csn_fall;
    logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

    m10_spi_sync u_sync_sclk (.clk(clk), .reset(reset), .d(spi_clk),
                              .level(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    m10_spi_sync u_sync_csn  (.clk(clk), .reset(reset), .d(spi_csn),
                              .level(csn_lvl), .rise(csn_rise), .fall(csn_fall));
    m10_spi_sync u_sync_mosi (.clk(clk), .reset(reset), .d(spi_mosi),
                              .level(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

`ifndef M10_SPI_STATS_EN
    wire [CNT_W-1:0] unused_cnt_w = '0;
`endif

    spi_state_e        state;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] rx_shift;
    logic [BYTE_W-1:0] tx_shift;
    logic              byte_seen;

    logic              active;
    logic [BYTE_W-1:0] rx_next;
    logic              byte_done;
    logic              tx_load;
    logic              rx_take;

    always_comb begin
        active    = (state == ACTIVE);
        rx_next   = {rx_shift[BYTE_W-2:0], mosi_lvl};
        byte_done = active && sclk_rise && (bit_cnt == 3'd7);
        // A byte boundary reload only happens once the frame has delivered a byte, so the
        // first falling edge after the frame-start load shifts instead of popping again.
        tx_load   = csn_fall || (active && sclk_fall && (bit_cnt == 3'd0) && byte_seen);
        rx_take   = rx_valid && rx_ready;
    end

    assign spi_miso = tx_shift[BYTE_W-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            byte_seen   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overflow <= 1'b0;
            tx_underrun <= 1'b0;
            tx_ready    <= 1'b0;
            spi_miso_oe <= 1'b0;
`ifdef M10_SPI_STATS_EN
            frame_cnt   <= '0;
            byte_cnt    <= '0;
`endif
        end else begin
            tx_ready    <= tx_load && tx_valid;
            spi_miso_oe <= !csn_lvl && (active || csn_fall);

            if (tx_load) begin
                tx_shift <= tx_valid ? tx_data : IDLE_BYTE;
            end else if (active && sclk_fall) begin
                tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
            end

            if (csn_fall) begin
                state     <= ACTIVE;
                bit_cnt   <= 3'd0;
                byte_seen <= 1'b0;
            end else if (active && csn_rise) begin
                state <= IDLE;
`ifdef M10_SPI_STATS_EN
                if (byte_seen) frame_cnt <= frame_cnt + 1'b1;
`endif
            end else if (active && sclk_rise) begin
                rx_shift <= rx_next;
                bit_cnt  <= bit_cnt + 3'd1;
                if (byte_done) byte_seen <= 1'b1;
            end

            // A same-cycle handshake frees the holding register for the new byte.
            if (byte_done && (!rx_valid || rx_take)) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
            end else if (rx_take) begin
                rx_valid <= 1'b0;
            end

            if (err_clr)                                 rx_overflow <= 1'b0;
            else if (byte_done && rx_valid && !rx_ready) rx_overflow <= 1'b1;

            if (err_clr)                    tx_underrun <= 1'b0;
            else if (tx_load && !tx_valid)  tx_underrun <= 1'b1;

`ifdef M10_SPI_STATS_EN
            if (byte_done) byte_cnt <= byte_cnt + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_m10_spi_slave_responder.sv
// Bench for m10_spi_slave_responder: SPI mode-0 master, tx source and rx consumer, with a
// frame-level reference model (loads = completed bytes + 1, each load pops or underruns).
module tb_m10_spi_slave_responder;

    localparam int          HALF   = 8;
    localparam logic [7:0]  IDLE_B = 8'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_clk, spi_csn, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready, rx_overflow;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, tx_underrun;
    logic       err_clr;
`ifdef M10_SPI_STATS_EN
    logic [15:0] frame_cnt, byte_cnt;
    int          exp_frames = 0;
    int          exp_bytes  = 0;
`endif

    m10_spi_slave_responder dut (
        .clk(clk), .reset(reset),
        .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overflow(rx_overflow),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_underrun(tx_underrun),
        .err_clr(err_clr)
`ifdef M10_SPI_STATS_EN
        , .frame_cnt(frame_cnt), .byte_cnt(byte_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // tx source: circular store written by the stimulus, read pointer advanced on each pop.
    logic [7:0] tx_mem [256];
    int         tx_wr = 0;
    int         tx_rd = 0;
    logic [7:0] got_q  [$];
    logic [7:0] mosi_q [$];
    logic [7:0] src_q  [$];
    logic [7:0] miso_q [$];

    assign tx_valid = (tx_rd != tx_wr);
    assign tx_data  = tx_mem[tx_rd[7:0]];

    always @(negedge clk) begin
        if (tx_ready) tx_rd <= tx_rd + 1;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = mo[i];
            wclk(HALF);
            mi[i]   = spi_miso;
            spi_clk = 1'b1;
            wclk(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        wclk(1);
        err_clr = 1'b0;
        wclk(1);
        check("err_clr_ovf", 32'(rx_overflow), 32'd0);
        check("err_clr_und", 32'(tx_underrun), 32'd0);
    endtask

    // Runs one frame of mosi_q full bytes plus `partial` trailing bits against src_q.
    task automatic do_frame(input int partial, input string tag);
        int         loads, base_rd, base_got, nsrc, exp_pops;
        logic [7:0] b, exp_b;
        tx_wr = tx_rd;
        foreach (src_q[k]) begin
            tx_mem[tx_wr[7:0]] = src_q[k];
            tx_wr++;
        end
        base_rd  = tx_rd;
        base_got = got_q.size();
        miso_q.delete();
        wclk(2);
        spi_csn = 1'b0;
        wclk(HALF);
        check({tag, "_oe_on"}, 32'(spi_miso_oe), 32'd1);
        foreach (mosi_q[k]) begin
            spi_xfer(mosi_q[k], 8, b);
            miso_q.push_back(b);
        end
        if (partial > 0) spi_xfer(8'($urandom), partial, b);
        wclk(HALF);
        spi_csn = 1'b1;
        wclk(4 * HALF);
        check({tag, "_oe_off"}, 32'(spi_miso_oe), 32'd0);

        nsrc     = src_q.size();
        loads    = mosi_q.size() + 1;
        exp_pops = (loads < nsrc) ? loads : nsrc;
        foreach (miso_q[k]) begin
            exp_b = (k < nsrc) ? src_q[k] : IDLE_B;
            check($sformatf("%s_miso%0d", tag, k), 32'(miso_q[k]), 32'(exp_b));
        end
        check({tag, "_pops"}, 32'(tx_rd - base_rd), 32'(exp_pops));
        check({tag, "_underrun"}, 32'(tx_underrun), 32'(loads > nsrc));
        if (rx_ready) begin
            check({tag, "_rx_count"}, 32'(got_q.size() - base_got), 32'(mosi_q.size()));
            foreach (mosi_q[k])
                if (base_got + k < got_q.size())
                    check($sformatf("%s_rx%0d", tag, k), 32'(got_q[base_got + k]), 32'(mosi_q[k]));
            check({tag, "_rx_valid_idle"}, 32'(rx_valid), 32'd0);
        end
`ifdef M10_SPI_STATS_EN
        if (mosi_q.size() > 0) exp_frames++;
        exp_bytes += mosi_q.size();
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames[15:0]));
        check({tag, "_byte_cnt"}, 32'(byte_cnt), 32'(exp_bytes[15:0]));
`endif
    endtask

    initial begin
        logic [7:0] b;
        int         nb, nt;
        reset    = 1'b1;
        spi_clk  = 1'b0;
        spi_csn  = 1'b1;
        spi_mosi = 1'b0;
        rx_ready = 1'b1;
        err_clr  = 1'b0;
        wclk(5);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_oe", 32'(spi_miso_oe), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_ovf", 32'(rx_overflow), 32'd0);
        check("rst_und", 32'(tx_underrun), 32'd0);
        reset = 1'b0;
        wclk(8);

        mosi_q = '{8'hA5};
        src_q  = '{8'h3C};
        do_frame(0, "single");
        clear_err();

        mosi_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        src_q  = '{8'h10, 8'h11, 8'h12, 8'h13};
        do_frame(0, "b2b");
        clear_err();

        rx_ready = 1'b0;
        mosi_q   = '{8'hAA, 8'hBB};
        src_q    = '{8'h55, 8'h66, 8'h77};
        do_frame(0, "ovf");
        check("ovf_rx_valid", 32'(rx_valid), 32'd1);
        check("ovf_rx_data", 32'(rx_data), 32'hAA);
        check("ovf_flag", 32'(rx_overflow), 32'd1);
        clear_err();
        rx_ready = 1'b1;
        wclk(3);
        check("ovf_drain_valid", 32'(rx_valid), 32'd0);
        check("ovf_drain_data", 32'(got_q[got_q.size() - 1]), 32'hAA);

        mosi_q = '{8'h96};
        src_q.delete();
        do_frame(0, "underrun");
        clear_err();

        mosi_q.delete();
        src_q = '{8'($urandom)};
        do_frame(5, "partial");
        clear_err();
        mosi_q = '{8'h5A};
        src_q  = '{8'hE7, 8'h18};
        do_frame(0, "after_partial");
        clear_err();

        // Abort a frame three bits in with reset, then start cleanly.
        spi_csn = 1'b0;
        wclk(HALF);
        spi_xfer(8'hFF, 3, b);
        reset = 1'b1;
        wclk(2);
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check("midrst_miso", 32'(spi_miso), 32'd0);
        check("midrst_oe", 32'(spi_miso_oe), 32'd0);
        check("midrst_und", 32'(tx_underrun), 32'd0);
        check("midrst_tx_ready", 32'(tx_ready), 32'd0);
        spi_csn = 1'b1;
        wclk(4);
        reset = 1'b0;
`ifdef M10_SPI_STATS_EN
        exp_frames = 0;
        exp_bytes  = 0;
`endif
        wclk(16);
        mosi_q = '{8'hC3};
        src_q  = '{8'h81};
        do_frame(0, "post_rst");
        clear_err();

        for (int f = 0; f < 6; f++) begin
            nb = $urandom_range(1, 4);
            nt = $urandom_range(0, 5);
            mosi_q.delete();
            src_q.delete();
            for (int k = 0; k < nb; k++) mosi_q.push_back(8'($urandom));
            for (int k = 0; k < nt; k++) src_q.push_back(8'($urandom));
            do_frame(0, $sformatf("rand%0d", f));
            clear_err();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
